// File: rtl/approx_mult_err_monitor_if.sv
// Sample/control/result bundle between the characterisation harness (master)
// and the approximate-multiplier error monitor (slave).
interface approx_mult_err_monitor_if #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned ACC_W = 40
);
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       x;
  logic [7:0]       y;
  logic [15:0]      z_approx;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] sum_abs_err;
  logic [ACC_W:0]   sum_err;
  logic [15:0]      max_abs_err;

  modport master (
    output start, n_samples, in_valid, x, y, z_approx,
    input  in_ready, busy, done, sample_cnt, err_cnt,
           sum_abs_err, sum_err, max_abs_err
  );

  modport slave (
    input  start, n_samples, in_valid, x, y, z_approx,
    output in_ready, busy, done, sample_cnt, err_cnt,
           sum_abs_err, sum_err, max_abs_err
  );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for unsigned 8x8 approximate multipliers.
// Accepts (x, y, z_approx) samples over a programmable window, recomputes the
// exact product and accumulates count/sum/abs-sum/max of z_approx - x*y.
module approx_mult_err_monitor #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned ACC_W = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  approx_mult_err_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] n_lat;
  logic             accept;
  logic             start_take;

  logic             s1_valid;
  logic [15:0]      s1_exact;
  logic [15:0]      s1_z;
  logic [16:0]      e;
  logic [15:0]      abs_e;

  // Handshake qualifiers: accepted sample and an honoured start pulse.
  always_comb begin
    accept     = mon.in_valid && mon.in_ready;
    start_take = mon.start && ((state == IDLE) || (state == DONE));
  end

  // Signed error and its magnitude; the magnitude always fits in 16 bits.
  always_comb begin
    e     = {1'b0, s1_z} - {1'b0, s1_exact};
    abs_e = e[16] ? (s1_exact - s1_z) : e[15:0];
  end

  // Window control FSM with registered in_ready/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc_cnt      <= '0;
      n_lat        <= '0;
      mon.in_ready <= 1'b0;
      mon.busy     <= 1'b0;
      mon.done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (mon.start) begin
            acc_cnt <= '0;
            n_lat   <= mon.n_samples;
            if (mon.n_samples == '0) begin
              state        <= DONE;
              mon.in_ready <= 1'b0;
              mon.busy     <= 1'b0;
              mon.done     <= 1'b1;
            end else begin
              state        <= RUN;
              mon.in_ready <= 1'b1;
              mon.busy     <= 1'b1;
              mon.done     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt + CNT_W'(1) == n_lat) begin
              state        <= DRAIN;
              mon.in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state    <= DONE;
          mon.busy <= 1'b0;
          mon.done <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          mon.in_ready <= 1'b0;
          mon.busy     <= 1'b0;
          mon.done     <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage datapath: stage 1 registers exact product, stage 2 accumulates.
  // start can only be honoured outside RUN/DRAIN, so it never collides with a
  // valid stage-1 entry; the clear therefore takes priority without loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_exact        <= '0;
      s1_z            <= '0;
      mon.sample_cnt  <= '0;
      mon.err_cnt     <= '0;
      mon.sum_abs_err <= '0;
      mon.sum_err     <= '0;
      mon.max_abs_err <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact <= 16'(mon.x) * 16'(mon.y);
        s1_z     <= mon.z_approx;
      end
      if (start_take) begin
        s1_valid        <= 1'b0;
        mon.sample_cnt  <= '0;
        mon.err_cnt     <= '0;
        mon.sum_abs_err <= '0;
        mon.sum_err     <= '0;
        mon.max_abs_err <= '0;
      end else if (s1_valid) begin
        mon.sample_cnt  <= mon.sample_cnt + CNT_W'(1);
        mon.err_cnt     <= mon.err_cnt + CNT_W'(e != '0);
        mon.sum_abs_err <= mon.sum_abs_err + {{(ACC_W-16){1'b0}}, abs_e};
        mon.sum_err     <= mon.sum_err + {{(ACC_W-16){e[16]}}, e};
        if (abs_e > mon.max_abs_err) begin
          mon.max_abs_err <= abs_e;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed self-checking bench for approx_mult_err_monitor.
module tb_approx_mult_err_monitor;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned ACC_W = 40;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  approx_mult_err_monitor_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) mon ();

  approx_mult_err_monitor #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [63:0] cnt, input logic [63:0] errs,
                            input logic [63:0] sabs, input logic [ACC_W:0] serr,
                            input logic [63:0] mx);
    check({tag, ".sample_cnt"},  64'(mon.sample_cnt),  cnt);
    check({tag, ".err_cnt"},     64'(mon.err_cnt),     errs);
    check({tag, ".sum_abs_err"}, 64'(mon.sum_abs_err), sabs);
    check({tag, ".sum_err"},     64'(mon.sum_err),     64'(serr));
    check({tag, ".max_abs_err"}, 64'(mon.max_abs_err), mx);
  endtask

  task automatic expect_flags(input string tag, input logic rdy, input logic bsy, input logic dn);
    check({tag, ".in_ready"}, 64'(mon.in_ready), 64'(rdy));
    check({tag, ".busy"},     64'(mon.busy),     64'(bsy));
    check({tag, ".done"},     64'(mon.done),     64'(dn));
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    mon.n_samples = n;
    mon.start     = 1'b1;
    step();
    mon.start     = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] z);
    mon.in_valid = v;
    mon.x        = a;
    mon.y        = b;
    mon.z_approx = z;
  endtask

  logic [ACC_W:0] neg_extreme;
  logic [1:0]     flow_pat [8];
  int             accepts;
  logic           done_at_c1;

  initial begin
    neg_extreme = -(ACC_W+1)'(65025);
    flow_pat    = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};

    // Reset, with start asserted alongside to show rst wins.
    rst           = 1'b1;
    mon.start     = 1'b1;
    mon.n_samples = 24'd5;
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    step();
    step();
    mon.start = 1'b0;
    expect_flags("rst", 1'b0, 1'b0, 1'b0);
    expect_res("rst", 0, 0, 0, '0, 0);
    rst = 1'b0;
    step();
    expect_flags("idle", 1'b0, 1'b0, 1'b0);

    // Exact stream over every operand pair.
    pulse_start(24'd65536);
    expect_flags("exact.s1", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, i[15:8], i[7:0], 16'(i[15:8]) * 16'(i[7:0]));
      step();
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    expect_flags("exact.drain", 1'b0, 1'b1, 1'b0);
    step();
    expect_flags("exact.done", 1'b0, 1'b0, 1'b1);
    expect_res("exact", 65536, 0, 0, '0, 0);

    // Biased stream, back-to-back from DONE; a start mid-window is ignored.
    pulse_start(24'd10);
    for (int i = 0; i < 10; i++) begin
      logic [7:0]  a;
      logic [15:0] p;
      a = 8'(i + 1);
      p = 16'(a) * 16'd7;
      drive(1'b1, a, 8'd7, (i < 5) ? p + 16'd3 : p - 16'd2);
      if (i == 5) begin
        mon.start     = 1'b1;
        mon.n_samples = 24'd3;
      end
      step();
      mon.start = 1'b0;
      check($sformatf("bias.lat%0d", i), 64'(mon.sample_cnt), 64'(i));
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    step();
    expect_flags("bias.done", 1'b0, 1'b0, 1'b1);
    expect_res("bias", 10, 10, 25, (ACC_W+1)'(5), 3);

    // Extreme negative error.
    pulse_start(24'd1);
    drive(1'b1, 8'd255, 8'd255, 16'd0);
    step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    step();
    expect_flags("ext.done", 1'b0, 1'b0, 1'b1);
    expect_res("ext", 1, 1, 65025, neg_extreme, 65025);

    // Flow control with gaps and an extra valid after the window fills.
    pulse_start(24'd4);
    accepts    = 0;
    done_at_c1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = 8'(i + 1);
      drive(flow_pat[i][0], a, 8'd2, 16'(a) * 16'd2 + 16'd1);
      if (mon.in_valid && mon.in_ready) accepts++;
      step();
      if (i == 6) begin
        check("flow.ready_after4", 64'(mon.in_ready), 64'd0);
        done_at_c1 = mon.done;
      end
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    check("flow.accepts", 64'(accepts), 64'd4);
    check("flow.done_c1", 64'(done_at_c1), 64'd0);
    expect_flags("flow.done_c2", 1'b0, 1'b0, 1'b1);
    expect_res("flow", 4, 4, 4, (ACC_W+1)'(4), 1);

    // Zero-length window, then a short window from DONE.
    pulse_start(24'd0);
    expect_flags("zero", 1'b0, 1'b0, 1'b1);
    expect_res("zero", 0, 0, 0, '0, 0);
    pulse_start(24'd2);
    drive(1'b1, 8'd3, 8'd4, 16'd17);
    step();
    drive(1'b1, 8'd10, 8'd10, 16'd105);
    step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    step();
    expect_flags("restart", 1'b0, 1'b0, 1'b1);
    expect_res("restart", 2, 2, 10, (ACC_W+1)'(10), 5);

    // Reset after 3 of 8 samples.
    pulse_start(24'd8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'd9, 8'(i + 2), 16'd1);
      step();
    end
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_flags("midrst", 1'b0, 1'b0, 1'b0);
    expect_res("midrst", 0, 0, 0, '0, 0);
    pulse_start(24'd1);
    drive(1'b1, 8'd2, 8'd2, 16'd4);
    step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    step();
    expect_flags("post_rst", 1'b0, 1'b0, 1'b1);
    expect_res("post_rst", 1, 0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
